store_monitor: RTL and testbench



---
 rtl/store_mon_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/store_monitor.sv | 97 +++++++++
 tb/tb_store_monitor.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/store_mon_pkg.sv
// Shared types and default constants for the store-bus monitor.
// The verdict helper keeps the pass/fail rule in one place.
package store_mon_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PASS = 2'd1,
        FAIL = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } trc_entry_t;

    localparam logic [31:0] DEF_PASS_ADDR    = 32'd100;
    localparam logic [31:0] DEF_PASS_DATA    = 32'd7;
    localparam logic [31:0] DEF_SCRATCH_ADDR = 32'd96;

    // Outcome of one store seen while still running.
    function automatic state_t store_verdict(
        input logic [31:0] adr,
        input logic [31:0] data,
        input logic [31:0] pass_addr,
        input logic [31:0] pass_data,
        input logic [31:0] scratch_addr
    );
        if (adr == pass_addr && data == pass_data) begin
            return PASS;
        end else if (adr != scratch_addr) begin
            return FAIL;
        end else begin
            return RUN;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO with extra-MSB pointers.
// The head register presents the oldest entry and holds its last value once empty.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         full,
    input  logic         pop,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  head_q, head_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = head_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (do_push ? PW'(1) : PW'(0));
        rd_ptr_d = rd_ptr_q + (do_pop ? PW'(1) : PW'(0));
        head_d   = head_q;
        if (rd_ptr_d != wr_ptr_d) begin
            // The new head is the entry being written this edge when it is the only one.
            if (do_push && rd_ptr_d == wr_ptr_q) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/store_monitor.sv
// Watches the processor store bus: traces every store while running and
// latches a sticky pass/fail verdict for hardware self-check builds.
module store_monitor
    import store_mon_pkg::*;
#(
    parameter int          DEPTH        = 8,
    parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA    = DEF_PASS_DATA,
    parameter logic [31:0] SCRATCH_ADDR = DEF_SCRATCH_ADDR,
    parameter int          CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_write,
    input  logic [31:0]      data_adr,
    input  logic [31:0]      write_data,
    output logic             trc_valid,
    input  logic             trc_ready,
    output logic [31:0]      trc_adr,
    output logic [31:0]      trc_data,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             done,
    output logic             pass,
    output logic             fail
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    trc_entry_t       push_entry, head_entry;
    logic             fifo_full, fifo_empty;
    logic             push_req, push_ok, pop;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: only stores seen while running can decide the verdict.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && mem_write) begin
            state_d = store_verdict(data_adr, write_data,
                                    PASS_ADDR, PASS_DATA, SCRATCH_ADDR);
        end
    end

    // FSM outputs.
    always_comb begin
        pass = (state_q == PASS);
        fail = (state_q == FAIL);
        done = pass || fail;
    end

    // A full FIFO still takes a store when its head leaves on the same edge.
    always_comb begin
        pop        = trc_valid && trc_ready;
        push_req   = (state_q == RUN) && mem_write;
        push_ok    = push_req && (!fifo_full || pop);
        push_entry = '{adr: data_adr, data: write_data};
        drop_cnt_d = drop_cnt_q;
        if (push_req && !push_ok && drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(trc_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .push_data (push_entry),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    assign trc_valid = !fifo_empty;
    assign trc_adr   = head_entry.adr;
    assign trc_data  = head_entry.data;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor with a queue scoreboard of expected trace entries
// and a small model of the verdict, drop counter and head-hold behaviour.
module tb_store_monitor;
    import store_mon_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             mem_write;
    logic [31:0]      data_adr;
    logic [31:0]      write_data;
    logic             trc_valid;
    logic             trc_ready;
    logic [31:0]      trc_adr;
    logic [31:0]      trc_data;
    logic [CNT_W-1:0] drop_cnt;
    logic             done;
    logic             pass;
    logic             fail;

    store_monitor #(
        .DEPTH        (DEPTH),
        .PASS_ADDR    (32'd100),
        .PASS_DATA    (32'd7),
        .SCRATCH_ADDR (32'd96),
        .CNT_W        (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_adr   (data_adr),
        .write_data (write_data),
        .trc_valid  (trc_valid),
        .trc_ready  (trc_ready),
        .trc_adr    (trc_adr),
        .trc_data   (trc_data),
        .drop_cnt   (drop_cnt),
        .done       (done),
        .pass       (pass),
        .fail       (fail)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    trc_entry_t exp_q[$];
    trc_entry_t m_last;
    bit         m_pass, m_fail;
    int         m_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_last = '0;
        m_pass = 1'b0;
        m_fail = 1'b0;
        m_drop = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, trc_valid, 1'b0);
        check({tag, "_adr"},   trc_adr,   32'd0);
        check({tag, "_data"},  trc_data,  32'd0);
        check({tag, "_drop"},  drop_cnt,  '0);
        check({tag, "_done"},  done,      1'b0);
        check({tag, "_pass"},  pass,      1'b0);
        check({tag, "_fail"},  fail,      1'b0);
    endtask

    // Pulse reset away from any clock edge and verify the cleared outputs.
    task automatic do_reset();
        mem_write = 1'b0;
        trc_ready = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_values("rst");
        model_clear();
        reset = 1'b1;
        #1;
    endtask

    // One clock: drive inputs, check the head before the edge, update the model, check after.
    task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] dat,
                        input logic rdy);
        bit         do_pop;
        bit         do_push;
        trc_entry_t ent;
        mem_write  = mw;
        data_adr   = adr;
        write_data = dat;
        trc_ready  = rdy;
        #1;
        check("pre_valid", trc_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            check("head_adr",  trc_adr,  exp_q[0].adr);
            check("head_data", trc_data, exp_q[0].data);
        end
        do_pop  = rdy && exp_q.size() > 0;
        do_push = mw && !m_pass && !m_fail;
        if (do_pop) begin
            ent = exp_q.pop_front();
        end
        if (do_push) begin
            ent = '{adr: adr, data: dat};
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(ent);
            end else if (m_drop < (1 << CNT_W) - 1) begin
                m_drop++;
            end
            if (adr == 32'd100 && dat == 32'd7) begin
                m_pass = 1'b1;
            end else if (adr != 32'd96) begin
                m_fail = 1'b1;
            end
        end
        if (exp_q.size() > 0) begin
            m_last = exp_q[0];
        end
        @(posedge clk);
        #1;
        check("valid",    trc_valid, exp_q.size() > 0);
        check("hold_adr", trc_adr,   m_last.adr);
        check("hold_dat", trc_data,  m_last.data);
        check("drop_cnt", drop_cnt,  m_drop);
        check("pass",     pass,      m_pass);
        check("fail",     fail,      m_fail);
        check("done",     done,      m_pass || m_fail);
    endtask

    task automatic drain_all();
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b1);
        end
        step(1'b0, 32'd0, 32'd0, 1'b1);
    endtask

    initial begin
        reset      = 1'b0;
        mem_write  = 1'b0;
        data_adr   = '0;
        write_data = '0;
        trc_ready  = 1'b0;
        model_clear();
        #12;
        check_reset_values("init");
        reset = 1'b1;
        #1;

        // Scratch stores then the pass store, nothing drained yet.
        step(1'b1, 32'd96,  32'd3, 1'b0);
        step(1'b1, 32'd96,  32'd5, 1'b0);
        step(1'b1, 32'd100, 32'd7, 1'b0);
        step(1'b1, 32'd96,  32'd9, 1'b0);
        drain_all();

        // Stray address fails; a later pass store is neither captured nor effective.
        do_reset();
        step(1'b1, 32'd104, 32'd1, 1'b0);
        step(1'b1, 32'd100, 32'd7, 1'b0);
        drain_all();

        // Pass address with the wrong data fails but is still traced.
        do_reset();
        step(1'b1, 32'd100, 32'd6, 1'b0);
        drain_all();

        // Overfill: DEPTH+3 stores with no consumer.
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) begin
            step(1'b1, 32'd96, 32'h10 + i, 1'b0);
        end
        // Full FIFO, push and pop on the same edge: no drop, new entry at the tail.
        step(1'b1, 32'd96, 32'hAA, 1'b1);
        drain_all();
        // Streaming push/pop across several pointer wraps.
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1'b1, 32'd96, 32'h100 + i, 1'b1);
        end
        drain_all();

        // Asynchronous reset in the middle of a burst with entries queued.
        do_reset();
        for (int i = 0; i < DEPTH / 2; i++) begin
            step(1'b1, 32'd96, 32'h200 + i, 1'b0);
        end
        mem_write = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_clear();
        mem_write = 1'b0;
        #1;
        reset = 1'b1;
        step(1'b1, 32'd100, 32'd7, 1'b0);
        drain_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
